// File: rtl/gobou_ctrl_core_if.sv
// ctrl_bus: start/valid/stop control bundle that travels alongside data
// through the gobou MAC pipeline.
//   start - first beat of a batch
//   valid - beat carries a live input neuron
//   stop  - last beat of a batch
// Modports: master drives the bundle, slave observes it.
interface ctrl_bus;
    logic start;
    logic valid;
    logic stop;

    modport master (output start, output valid, output stop);
    modport slave  (input  start, input  valid, input  stop);
endinterface

// File: rtl/gobou_ctrl_core.sv
// gobou_ctrl_core: layer sequencer for the gobou fully-connected engine.
// Walks every output batch (CORE neurons at a time) and every input neuron,
// driving memory addresses and the control bus at the pipeline head, then
// waits for the batch to drain (in_ctrl.stop) before the next batch.
// Ports:
//   clk, rst        - clock, synchronous active-high reset
//   req / ack       - start pulse (IDLE only) / ready-or-done
//   in_size,out_size- neuron counts (>=1), latched on accepted req
//   in/w/out_offset - base addresses, latched on accepted req
//   in_ctrl         - control bus from the pipeline tail (stop only)
//   out_ctrl        - control bus to the pipeline head
//   input_addr, weight_addr, output_addr, n_valid - registered batch outputs
module gobou_ctrl_core #(
    parameter int CORE    = 16,
    parameter int LWIDTH  = 10,
    parameter int MEMSIZE = 12
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       req,
    output logic                       ack,
    input  logic [LWIDTH-1:0]          in_size,
    input  logic [LWIDTH-1:0]          out_size,
    input  logic [MEMSIZE-1:0]         in_offset,
    input  logic [MEMSIZE-1:0]         w_offset,
    input  logic [MEMSIZE-1:0]         out_offset,
    ctrl_bus.slave                     in_ctrl,
    ctrl_bus.master                    out_ctrl,
    output logic [MEMSIZE-1:0]         input_addr,
    output logic [MEMSIZE-1:0]         weight_addr,
    output logic [MEMSIZE-1:0]         output_addr,
    output logic [$clog2(CORE):0]      n_valid
);
    localparam int NVW = $clog2(CORE) + 1;
    localparam logic [LWIDTH-1:0]  CORE_L = LWIDTH'(CORE);
    localparam logic [MEMSIZE-1:0] CORE_M = MEMSIZE'(CORE);
    localparam logic [LWIDTH-1:0]  ONE_L  = {{(LWIDTH-1){1'b0}}, 1'b1};
    localparam logic [LWIDTH-1:0]  ZERO_L = {LWIDTH{1'b0}};

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MAC  = 2'd1,
        ST_WAIT = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    // Live cores in a batch: remaining output neurons clipped to CORE.
    function automatic logic [NVW-1:0] nv_clip(input logic [LWIDTH-1:0] rem);
        if (rem > CORE_L) begin
            return NVW'(CORE);
        end else begin
            return NVW'(rem);
        end
    endfunction

    state_t             state_q, state_d;
    logic [LWIDTH-1:0]  in_size_q, in_size_d;
    logic [LWIDTH-1:0]  rem_q, rem_d;       // output neurons not yet covered by earlier batches
    logic [LWIDTH-1:0]  i_q, i_d;           // index of the beat currently on the bus
    logic [MEMSIZE-1:0] in_off_q, in_off_d;
    logic [MEMSIZE-1:0] w_base_q, w_base_d;
    logic [MEMSIZE-1:0] o_base_q, o_base_d;
    logic               ack_q, ack_d;
    logic               start_q, start_d;
    logic               valid_q, valid_d;
    logic               stop_q, stop_d;
    logic [MEMSIZE-1:0] ia_q, ia_d;
    logic [MEMSIZE-1:0] wa_q, wa_d;
    logic [MEMSIZE-1:0] oa_q, oa_d;
    logic [NVW-1:0]     nv_q, nv_d;

    logic [LWIDTH-1:0]  i_nxt_s;
    logic [LWIDTH-1:0]  last_s;
    logic [LWIDTH-1:0]  rem_nxt_s;
    logic [MEMSIZE-1:0] w_base_nxt_s;
    logic [MEMSIZE-1:0] o_base_nxt_s;
    logic               unused_s;

    assign i_nxt_s      = i_q + ONE_L;
    assign last_s       = in_size_q - ONE_L;
    assign rem_nxt_s    = rem_q - CORE_L;
    assign w_base_nxt_s = w_base_q + MEMSIZE'(in_size_q);
    assign o_base_nxt_s = o_base_q + CORE_M;
    assign unused_s     = in_ctrl.start ^ in_ctrl.valid;

    // Next-state and registered-output computation.  The state register
    // tracks what is currently on the bus, so each branch prepares the beat
    // that appears after the coming edge.
    always_comb begin
        state_d   = state_q;
        in_size_d = in_size_q;
        rem_d     = rem_q;
        i_d       = i_q;
        in_off_d  = in_off_q;
        w_base_d  = w_base_q;
        o_base_d  = o_base_q;
        ack_d     = 1'b0;
        start_d   = 1'b0;
        valid_d   = 1'b0;
        stop_d    = 1'b0;
        ia_d      = ia_q;
        wa_d      = wa_q;
        oa_d      = oa_q;
        nv_d      = nv_q;
        case (state_q)
            ST_IDLE: begin
                if (req) begin
                    // First beat goes out straight from the request inputs.
                    state_d   = ST_MAC;
                    in_size_d = in_size;
                    rem_d     = out_size;
                    i_d       = ZERO_L;
                    in_off_d  = in_offset;
                    w_base_d  = w_offset;
                    o_base_d  = out_offset;
                    start_d   = 1'b1;
                    valid_d   = 1'b1;
                    stop_d    = (in_size == ONE_L);
                    ia_d      = in_offset;
                    wa_d      = w_offset;
                    oa_d      = out_offset;
                    nv_d      = nv_clip(out_size);
                end else begin
                    ack_d     = 1'b1;
                end
            end
            ST_MAC: begin
                if (i_q == last_s) begin
                    state_d = ST_WAIT;
                end else begin
                    i_d     = i_nxt_s;
                    valid_d = 1'b1;
                    stop_d  = (i_nxt_s == last_s);
                    ia_d    = in_off_q + MEMSIZE'(i_nxt_s);
                    wa_d    = w_base_q + MEMSIZE'(i_nxt_s);
                end
            end
            ST_WAIT: begin
                if (in_ctrl.stop) begin
                    if (rem_q > CORE_L) begin
                        state_d  = ST_MAC;
                        rem_d    = rem_nxt_s;
                        i_d      = ZERO_L;
                        w_base_d = w_base_nxt_s;
                        o_base_d = o_base_nxt_s;
                        start_d  = 1'b1;
                        valid_d  = 1'b1;
                        stop_d   = (in_size_q == ONE_L);
                        ia_d     = in_off_q;
                        wa_d     = w_base_nxt_s;
                        oa_d     = o_base_nxt_s;
                        nv_d     = nv_clip(rem_nxt_s);
                    end else begin
                        state_d  = ST_DONE;
                    end
                end else begin
                    state_d = ST_WAIT;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
                ack_d   = 1'b1;
            end
            default: begin
                state_d = ST_IDLE;
                ack_d   = 1'b1;
            end
        endcase
    end

    // State, latched parameters and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            in_size_q <= {LWIDTH{1'b0}};
            rem_q     <= {LWIDTH{1'b0}};
            i_q       <= {LWIDTH{1'b0}};
            in_off_q  <= {MEMSIZE{1'b0}};
            w_base_q  <= {MEMSIZE{1'b0}};
            o_base_q  <= {MEMSIZE{1'b0}};
            ack_q     <= 1'b1;
            start_q   <= 1'b0;
            valid_q   <= 1'b0;
            stop_q    <= 1'b0;
            ia_q      <= {MEMSIZE{1'b0}};
            wa_q      <= {MEMSIZE{1'b0}};
            oa_q      <= {MEMSIZE{1'b0}};
            nv_q      <= {NVW{1'b0}};
        end else begin
            state_q   <= state_d;
            in_size_q <= in_size_d;
            rem_q     <= rem_d;
            i_q       <= i_d;
            in_off_q  <= in_off_d;
            w_base_q  <= w_base_d;
            o_base_q  <= o_base_d;
            ack_q     <= ack_d;
            start_q   <= start_d;
            valid_q   <= valid_d;
            stop_q    <= stop_d;
            ia_q      <= ia_d;
            wa_q      <= wa_d;
            oa_q      <= oa_d;
            nv_q      <= nv_d;
        end
    end

    assign ack            = ack_q;
    assign out_ctrl.start = start_q;
    assign out_ctrl.valid = valid_q;
    assign out_ctrl.stop  = stop_q;
    assign input_addr     = ia_q;
    assign weight_addr    = wa_q;
    assign output_addr    = oa_q;
    assign n_valid        = nv_q;
endmodule

// File: tb/tb_gobou_ctrl_core.sv
// Directed testbench for gobou_ctrl_core. Outputs are sampled 1ns after the
// rising edge; inputs are changed at that same point so they are stable for
// the next edge. "Cycle k" outputs are those visible after edge k-1.
module tb_gobou_ctrl_core;
    logic        clk = 1'b0;
    logic        rst;
    logic        req;
    logic        ack;
    logic [9:0]  in_size, out_size;
    logic [11:0] in_offset, w_offset, out_offset;
    logic [11:0] input_addr, weight_addr, output_addr;
    logic [4:0]  n_valid;
    int          checks = 0;
    int          errors = 0;

    ctrl_bus in_bus ();
    ctrl_bus out_bus ();

    gobou_ctrl_core #(.CORE(16), .LWIDTH(10), .MEMSIZE(12)) dut (
        .clk(clk), .rst(rst), .req(req), .ack(ack),
        .in_size(in_size), .out_size(out_size),
        .in_offset(in_offset), .w_offset(w_offset), .out_offset(out_offset),
        .in_ctrl(in_bus.slave), .out_ctrl(out_bus.master),
        .input_addr(input_addr), .weight_addr(weight_addr),
        .output_addr(output_addr), .n_valid(n_valid)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_layer(input int isz, input int osz, input int io, input int wo, input int oo);
        in_size = 10'(isz); out_size = 10'(osz);
        in_offset = 12'(io); w_offset = 12'(wo); out_offset = 12'(oo);
        req = 1'b1;
        tick();
        req = 1'b0;
    endtask

    task automatic pulse_stop();
        in_bus.stop = 1'b1;
        tick();
        in_bus.stop = 1'b0;
    endtask

    // Check n back-to-back beats starting at the one currently visible,
    // then the idle-bus cycle that follows.
    task automatic check_beats(input string tag, input int n, input int ia0, input int wa0,
                               input int oa, input int nv);
        logic [11:0] ea, ew;
        for (int k = 0; k < n; k++) begin
            ea = 12'(ia0 + k);
            ew = 12'(wa0 + k);
            check_eq({tag, " valid"}, 32'(out_bus.valid), 32'd1);
            check_eq({tag, " start"}, 32'(out_bus.start), (k == 0) ? 32'd1 : 32'd0);
            check_eq({tag, " stop"},  32'(out_bus.stop),  (k == n - 1) ? 32'd1 : 32'd0);
            check_eq({tag, " iaddr"}, 32'(input_addr),  32'(ea));
            check_eq({tag, " waddr"}, 32'(weight_addr), 32'(ew));
            check_eq({tag, " oaddr"}, 32'(output_addr), 32'(oa));
            check_eq({tag, " nvalid"}, 32'(n_valid),    32'(nv));
            check_eq({tag, " ack"},   32'(ack),         32'd0);
            tick();
        end
        check_eq({tag, " idle valid"}, 32'(out_bus.valid), 32'd0);
        check_eq({tag, " idle start"}, 32'(out_bus.start), 32'd0);
        check_eq({tag, " hold iaddr"}, 32'(input_addr), 32'(12'(ia0 + n - 1)));
    endtask

    // Expected weight addresses around the 12-bit wrap point.
    logic [11:0] wrap_exp [4] = '{12'd4094, 12'd4095, 12'd0, 12'd1};

    initial begin
        rst = 1'b1; req = 1'b0;
        in_size = 10'd0; out_size = 10'd0;
        in_offset = 12'd0; w_offset = 12'd0; out_offset = 12'd0;
        in_bus.start = 1'b0; in_bus.valid = 1'b0; in_bus.stop = 1'b0;
        tick(); tick();
        rst = 1'b0;

        // Reset state
        check_eq("rst ack", 32'(ack), 32'd1);
        check_eq("rst valid", 32'(out_bus.valid), 32'd0);
        check_eq("rst start", 32'(out_bus.start), 32'd0);
        check_eq("rst stop", 32'(out_bus.stop), 32'd0);
        check_eq("rst iaddr", 32'(input_addr), 32'd0);
        check_eq("rst waddr", 32'(weight_addr), 32'd0);
        check_eq("rst oaddr", 32'(output_addr), 32'd0);
        check_eq("rst nvalid", 32'(n_valid), 32'd0);

        // Basic layer: beats at cycles 1-3, stop at cycle 8, ack at cycle 10
        start_layer(3, 16, 0, 0, 0);
        check_beats("t1", 3, 0, 0, 0, 16);   // now observing cycle 4
        tick(); tick(); tick(); tick();       // cycle 8
        check_eq("t1 wait ack", 32'(ack), 32'd0);
        pulse_stop();                         // cycle 9: DONE
        check_eq("t1 done ack", 32'(ack), 32'd0);
        tick();                               // cycle 10
        check_eq("t1 ack", 32'(ack), 32'd1);

        // Three batches with offsets
        start_layer(5, 40, 7, 100, 200);
        check_beats("t2b0", 5, 7, 100, 200, 16);
        tick(); tick();
        check_eq("t2 wait valid", 32'(out_bus.valid), 32'd0);
        pulse_stop();
        check_beats("t2b1", 5, 7, 105, 216, 16);
        pulse_stop();
        check_beats("t2b2", 5, 7, 110, 232, 8);
        pulse_stop();
        check_eq("t2 done ack", 32'(ack), 32'd0);
        tick();
        check_eq("t2 ack", 32'(ack), 32'd1);

        // Single input, single output neuron
        start_layer(1, 1, 3, 4, 5);
        check_eq("t3 start", 32'(out_bus.start), 32'd1);
        check_eq("t3 valid", 32'(out_bus.valid), 32'd1);
        check_eq("t3 stop", 32'(out_bus.stop), 32'd1);
        check_eq("t3 nvalid", 32'(n_valid), 32'd1);
        tick();
        check_eq("t3 after valid", 32'(out_bus.valid), 32'd0);
        pulse_stop();
        tick();
        check_eq("t3 ack", 32'(ack), 32'd1);

        // req and stale stop during MAC are ignored
        start_layer(6, 16, 0, 0, 0);
        for (int k = 0; k < 6; k++) begin
            check_eq("t4 valid", 32'(out_bus.valid), 32'd1);
            check_eq("t4 iaddr", 32'(input_addr), 32'(k));
            check_eq("t4 start", 32'(out_bus.start), (k == 0) ? 32'd1 : 32'd0);
            if (k == 2 || k == 5) begin
                req = 1'b1; in_bus.stop = 1'b1;
            end else begin
                req = 1'b0; in_bus.stop = 1'b0;
            end
            tick();
        end
        req = 1'b0; in_bus.stop = 1'b0;
        for (int k = 0; k < 3; k++) begin
            check_eq("t4 no restart", 32'(out_bus.valid), 32'd0);
            check_eq("t4 ack low", 32'(ack), 32'd0);
            tick();
        end
        pulse_stop();
        tick();
        check_eq("t4 ack", 32'(ack), 32'd1);

        // Weight address wraps modulo 2^12
        start_layer(4, 16, 0, 4094, 0);
        for (int k = 0; k < 4; k++) begin
            check_eq("t5 waddr", 32'(weight_addr), 32'(wrap_exp[k]));
            tick();
        end
        pulse_stop();
        tick();
        check_eq("t5 ack", 32'(ack), 32'd1);

        // Reset in the middle of batch 1, then restart with new offsets
        start_layer(4, 40, 10, 20, 30);
        check_beats("t6b0", 4, 10, 20, 30, 16);
        pulse_stop();
        check_eq("t6b1 beat0 waddr", 32'(weight_addr), 32'd24);
        tick();
        check_eq("t6b1 beat1 iaddr", 32'(input_addr), 32'd11);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_eq("t6 rst valid", 32'(out_bus.valid), 32'd0);
        check_eq("t6 rst ack", 32'(ack), 32'd1);
        check_eq("t6 rst iaddr", 32'(input_addr), 32'd0);
        check_eq("t6 rst waddr", 32'(weight_addr), 32'd0);
        check_eq("t6 rst oaddr", 32'(output_addr), 32'd0);
        check_eq("t6 rst nvalid", 32'(n_valid), 32'd0);
        start_layer(2, 20, 50, 60, 70);
        check_beats("t6r0", 2, 50, 60, 70, 16);
        pulse_stop();
        check_beats("t6r1", 2, 50, 62, 86, 4);
        pulse_stop();
        tick();
        check_eq("t6 ack", 32'(ack), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/gobou_ctrl_core.md
# gobou_ctrl_core

Layer sequencer for the gobou fully-connected engine. On a request it walks every output-neuron batch (CORE neurons in parallel) and every input neuron. It drives input and weight memory addresses plus the start/valid/stop control bus at the head of the MAC pipeline, where downstream stages such as the bias-delay stage consume it. It waits for each batch to drain out of the pipeline before starting the next, then reports completion.

## Interface
- CORE, 16, output neurons computed in parallel per batch
- LWIDTH, 10, width of the neuron-count inputs
- MEMSIZE, 12, width of all memory addresses
- clk  in  1  clock
- rst  in  1  synchronous reset, active-high
- req  in  1  start pulse; sampled only in IDLE
- ack  out  1  high while IDLE (ready / layer done)
- in_size  in  LWIDTH  input neurons, ≥1; latched on accepted req
- out_size  in  LWIDTH  output neurons, ≥1; latched on accepted req
- in_offset, w_offset, out_offset  in  MEMSIZE each  base addresses; latched on accepted req
- in_ctrl  ctrl_bus.slave  start/valid/stop returned from the pipeline tail; only stop is used
- out_ctrl  ctrl_bus.master  start/valid/stop to the pipeline head
- input_addr  out  MEMSIZE  input memory read address
- weight_addr  out  MEMSIZE  weight memory read address, shared by all CORE weight banks
- output_addr  out  MEMSIZE  write base for the current batch; held for the whole batch
- n_valid  out  log2(CORE)+1  live cores in the current batch

## Operation
- States: IDLE, MAC, WAIT, DONE.
- IDLE → MAC on req. Latch sizes and offsets. i=0, batch=0, w_base=w_offset, o_base=out_offset.
- MAC runs one input neuron per cycle.
  - input_addr=in_offset+i, weight_addr=w_base+i, out_ctrl.valid=1.
  - out_ctrl.start=1 on i=0 only. out_ctrl.stop=1 on i=in_size−1 only.
  - After i=in_size−1, go to WAIT.
- WAIT: all out_ctrl bits are 0; addresses hold their last values. On in_ctrl.stop=1:
  - If (batch+1)·CORE < out_size: batch++, w_base+=in_size, o_base+=CORE, i=0, go to MAC.
  - Otherwise go to DONE.
- DONE: lasts one cycle, then IDLE.
- n_valid = min(CORE, out_size − batch·CORE).
- Arithmetic:
  - No multipliers; bases advance by running accumulation.
  - All address sums wrap modulo 2^MEMSIZE.
- Ignored events:
  - req outside IDLE.
  - in_ctrl.stop outside WAIT, including a stale stop arriving during MAC.
- in_size=1: start, valid and stop are all high in the same single MAC cycle.
- rst at any time: next cycle the block is in IDLE with all registers at reset values. Outstanding pipeline data is abandoned.

## Timing
- All outputs are registered. Address outputs and out_ctrl change on the same edge, so they are aligned.
- Reset values:
  - ack=1.
  - out_ctrl.start/valid/stop=0.
  - input_addr, weight_addr, output_addr=0.
  - n_valid=0.
- req high at edge t (IDLE):
  - ack=0 from t+1.
  - First MAC beat (start=1, valid=1) at t+1.
- Beats are back-to-back: in_size consecutive valid cycles with no bubbles.
- Last beat at cycle s: WAIT from s+1.
- in_ctrl.stop at edge w:
  - Next batch's first beat at w+1.
  - Or, on the last batch: DONE at w+1, ack=1 at w+2.
- output_addr and n_valid update on the same edge as the first beat of their batch. They are stable from then until the next batch's first beat.
- Minimum layer time: batches·(in_size + pipeline depth + 1) + 2 cycles.

## Test plan
- in_size=3, out_size=16, offsets 0, req at cycle 0:
  - Beats at cycles 1–3; input_addr 0,1,2; weight_addr 0,1,2; start at cycle 1, stop at cycle 3.
  - Drive in_ctrl.stop at cycle 8 → ack=1 at cycle 10.
- in_size=5, out_size=40, w_offset=100, out_offset=200:
  - 3 batches; n_valid 16,16,8; output_addr 200,216,232.
  - First weight_addr per batch 100,105,110.
- in_size=1, out_size=1: a single cycle with start=valid=stop=1, n_valid=1.
- req pulsed during MAC, and in_ctrl.stop pulsed during MAC → no restart, no early batch advance; beat count stays exactly in_size.
- w_offset=2^MEMSIZE−2, in_size=4 → weight_addr sequence 4094,4095,0,1 (MEMSIZE=12).
- rst asserted at the 2nd beat of batch 1 → next cycle valid=0, ack=1, addresses 0. A new req then restarts from batch 0 with the new offsets.
